dmem_access_ctrl: RTL and testbench

- MEM-stage data-memory controller for the rv32i pipeline. It sits directly upstream of the writeback load-extraction logic.
- Turns MEM-stage load/store intent into a registered read/write/resp handshake with the data cache, and builds byte enables and lane-shifted store data.
- Holds the pipeline until the cache responds, guaranteeing each store is issued exactly once.
- Registers the raw 32-bit read word. WB sign/size extraction consumes that word.

---
 rtl/dmem_access_ctrl.sv | 128 ++++++++++++
 tb/tb_dmem_access_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory controller: turns load/store intent into a registered
// read/write/resp handshake with the data cache and holds the pipeline until it completes.
module dmem_access_ctrl #(
    parameter int MAX_WAIT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        mem_read_op,
    input  logic        mem_write_op,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_alu_out,
    input  logic [31:0] mem_rs2_out,
    input  logic        pipe_adv,
    input  logic        dcache_resp,
    input  logic [31:0] dcache_rdata,
    output logic        dcache_read,
    output logic        dcache_write,
    output logic [31:0] dcache_address,
    output logic [31:0] dcache_wdata,
    output logic [3:0]  dcache_byte_enable,
    output logic        dmem_stall,
    output logic [31:0] wb_mem_rdata,
    output logic        misalign_err,
    output logic        timeout_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    // Cache handshake: a request (dcache_read or dcache_write) is raised at the
    // issue edge and held stable until the first cycle dcache_resp is sampled
    // high in BUSY; the request drops at that same edge. resp is ignored elsewhere.
    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       a;
    logic             op_live;
    logic             mis_raw;
    logic             req;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata;

    assign a         = mem_alu_out[1:0];
    assign state_dbg = state;

    always_comb begin
        op_live = mem_valid & (mem_read_op | mem_write_op);
        case (mem_funct3[1:0])
            2'b00:   mis_raw = 1'b0;
            2'b01:   mis_raw = a[0];
            default: mis_raw = (a != 2'b00);
        endcase
        misalign_err = (state == IDLE) & op_live & mis_raw;
        req          = op_live & ~mis_raw;
        dmem_stall   = ((state == IDLE) & req) | (state == BUSY);

        case (mem_funct3[1:0])
            2'b00:   st_be = 4'b0001 << a;
            2'b01:   st_be = 4'b0011 << {a[1], 1'b0};
            default: st_be = 4'b1111;
        endcase
        st_wdata = mem_rs2_out << {a, 3'b000};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            dcache_read        <= 1'b0;
            dcache_write       <= 1'b0;
            dcache_address     <= 32'h0;
            dcache_wdata       <= 32'h0;
            dcache_byte_enable <= 4'b0000;
            wb_mem_rdata       <= 32'h0;
            timeout_err        <= 1'b0;
            wait_cnt           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        dcache_address <= {mem_alu_out[31:2], 2'b00};
                        wait_cnt       <= '0;
                        state          <= BUSY;
                        // A store wins when both op bits are set.
                        if (mem_write_op) begin
                            dcache_write       <= 1'b1;
                            dcache_wdata       <= st_wdata;
                            dcache_byte_enable <= st_be;
                        end else begin
                            dcache_read        <= 1'b1;
                            dcache_wdata       <= 32'h0;
                            dcache_byte_enable <= 4'b1111;
                        end
                    end
                end
                BUSY: begin
                    if (dcache_resp) begin
                        if (dcache_read) begin
                            wb_mem_rdata <= dcache_rdata;
                        end
                        dcache_read  <= 1'b0;
                        dcache_write <= 1'b0;
                        state        <= DONE;
                    end else if (MAX_WAIT > 0 && wait_cnt != WAIT_LIMIT) begin
                        // Counter saturates at the limit; the FSM keeps waiting.
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        if (wait_cnt + CNT_W'(1) == WAIT_LIMIT) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (pipe_adv) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: table-driven transactions, random transactions,
// and hand-written DONE-hold, reset-in-BUSY and watchdog sequences.
module tb_dmem_access_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_read_op;
    logic        mem_write_op;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_out;
    logic [31:0] mem_rs2_out;
    logic        pipe_adv;
    logic        dcache_resp;
    logic [31:0] dcache_rdata;
    logic        dcache_read;
    logic        dcache_write;
    logic [31:0] dcache_address;
    logic [31:0] dcache_wdata;
    logic [3:0]  dcache_byte_enable;
    logic        dmem_stall;
    logic [31:0] wb_mem_rdata;
    logic        misalign_err;
    logic        timeout_err;
    logic [1:0]  state_dbg;

    dmem_access_ctrl #(.MAX_WAIT(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .mem_valid          (mem_valid),
        .mem_read_op        (mem_read_op),
        .mem_write_op       (mem_write_op),
        .mem_funct3         (mem_funct3),
        .mem_alu_out        (mem_alu_out),
        .mem_rs2_out        (mem_rs2_out),
        .pipe_adv           (pipe_adv),
        .dcache_resp        (dcache_resp),
        .dcache_rdata       (dcache_rdata),
        .dcache_read        (dcache_read),
        .dcache_write       (dcache_write),
        .dcache_address     (dcache_address),
        .dcache_wdata       (dcache_wdata),
        .dcache_byte_enable (dcache_byte_enable),
        .dmem_stall         (dmem_stall),
        .wb_mem_rdata       (wb_mem_rdata),
        .misalign_err       (misalign_err),
        .timeout_err        (timeout_err),
        .state_dbg          (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Scoreboard: {read, write, address, wdata, byte_enable}
    logic [69:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          req_seen = 0;
    logic        prev_req = 1'b0;
    logic [69:0] mon_e;
    logic [31:0] model_rdata = 32'h0;

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare every newly raised cache request against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (dcache_read || dcache_write) && !prev_req) begin
            req_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_req", {dcache_read, dcache_write, dcache_address,
                      dcache_wdata, dcache_byte_enable}, 70'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check("req_fields", {dcache_read, dcache_write, dcache_address,
                      dcache_wdata, dcache_byte_enable}, mon_e);
            end
        end
        prev_req = rst_n && (dcache_read || dcache_write);
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        int          busy;
        logic [31:0] rdata;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t make_vec(input logic rd, input logic wr, input logic [2:0] f3,
                                      input logic [31:0] addr, input logic [31:0] rs2,
                                      input int busy, input logic [31:0] rdata);
        vec_t v;
        logic [1:0] a;
        a = addr[1:0];
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.rs2 = rs2;
        v.busy = busy; v.rdata = rdata;
        v.mis = (f3[1:0] == 2'b01) ? a[0] : (f3[1:0] == 2'b10) ? (a != 2'b00) : 1'b0;
        if (wr) begin
            if (f3[1:0] == 2'b00)      v.be = 4'b0001 << a;
            else if (f3[1:0] == 2'b01) v.be = a[1] ? 4'b1100 : 4'b0011;
            else                       v.be = 4'b1111;
            v.wdata = rs2 << {a, 3'b000};
        end else begin
            v.be    = 4'b1111;
            v.wdata = 32'h0;
        end
        return v;
    endfunction

    task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rs2);
        mem_valid    = 1'b1;
        mem_read_op  = rd;
        mem_write_op = wr;
        mem_funct3   = f3;
        mem_alu_out  = addr;
        mem_rs2_out  = rs2;
    endtask

    task automatic run_txn(input vec_t v);
        int stall_n;
        int req_n;
        stall_n = 0;
        req_n   = 0;
        @(posedge clk); #1;
        drive_op(v.rd, v.wr, v.f3, v.addr, v.rs2);
        pipe_adv = 1'b0;
        @(negedge clk);
        check("misalign", 70'(misalign_err), 70'(v.mis));
        if (v.mis) begin
            check("mis_stall", 70'(dmem_stall), 70'(0));
            @(posedge clk); #1;
            @(negedge clk);
            check("mis_no_req", 70'({dcache_read, dcache_write}), 70'(0));
            check("mis_state", 70'(state_dbg), 70'(S_IDLE));
            mem_valid = 1'b0;
            return;
        end
        exp_q.push_back({v.rd & ~v.wr, v.wr, {v.addr[31:2], 2'b00}, v.wdata, v.be});
        stall_n += int'(dmem_stall);
        for (int k = 1; k <= v.busy; k++) begin
            @(posedge clk); #1;
            dcache_resp  = (k == v.busy);
            dcache_rdata = v.rdata;
            @(negedge clk);
            stall_n += int'(dmem_stall);
            req_n   += int'(dcache_read | dcache_write);
        end
        @(posedge clk); #1;
        dcache_resp = 1'b0;
        @(negedge clk);
        check("done_state", 70'(state_dbg), 70'(S_DONE));
        check("done_stall", 70'(dmem_stall), 70'(0));
        check("stall_cycles", 70'(stall_n), 70'(v.busy + 1));
        check("req_cycles", 70'(req_n), 70'(v.busy));
        if (v.rd && !v.wr) model_rdata = v.rdata;
        check("wb_rdata", 70'(wb_mem_rdata), 70'(model_rdata));
        // A resp pulse in DONE must be ignored.
        @(posedge clk); #1;
        pipe_adv     = 1'b1;
        mem_valid    = 1'b0;
        dcache_resp  = 1'b1;
        dcache_rdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        pipe_adv    = 1'b0;
        dcache_resp = 1'b0;
        @(negedge clk);
        check("back_idle", 70'(state_dbg), 70'(S_IDLE));
        check("wb_after_spurious", 70'(wb_mem_rdata), 70'(model_rdata));
    endtask

    initial begin
        int stall_n;
        int done_n;
        int req_before;
        logic rd, wr;
        logic [2:0] f3;
        int sel;

        rst_n = 1'b0; mem_valid = 1'b0; mem_read_op = 1'b0; mem_write_op = 1'b0;
        mem_funct3 = 3'b000; mem_alu_out = 32'h0; mem_rs2_out = 32'h0;
        pipe_adv = 1'b0; dcache_resp = 1'b0; dcache_rdata = 32'h0;

        vecs[0]  = make_vec(1'b1, 1'b0, 3'b010, 32'h0000_1004, 32'h5555_AAAA, 3, 32'hDEAD_BEEF);
        vecs[1]  = make_vec(1'b0, 1'b1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 1, 32'hFFFF_FFFF);
        vecs[2]  = make_vec(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_5678, 2, 32'hFFFF_FFFF);
        vecs[3]  = make_vec(1'b1, 1'b0, 3'b001, 32'h0000_1001, 32'h0, 1, 32'h0);
        vecs[4]  = make_vec(1'b0, 1'b1, 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 1, 32'h0);
        vecs[5]  = make_vec(1'b1, 1'b0, 3'b100, 32'h0000_4002, 32'hFFFF_FFFF, 2, 32'h1122_3344);
        vecs[6]  = make_vec(1'b0, 1'b1, 3'b010, 32'h0000_3002, 32'h1, 1, 32'h0);
        vecs[7]  = make_vec(1'b0, 1'b1, 3'b000, 32'h0000_5001, 32'h1234_56FF, 1, 32'h0);
        vecs[8]  = make_vec(1'b1, 1'b0, 3'b101, 32'h0000_6002, 32'h0, 1, 32'h8000_0001);
        vecs[9]  = make_vec(1'b1, 1'b1, 3'b010, 32'h0000_7000, 32'h0BAD_C0DE, 2, 32'h7777_7777);
        vecs[10] = make_vec(1'b0, 1'b1, 3'b001, 32'h0000_2001, 32'h0, 1, 32'h0);
        vecs[11] = make_vec(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 2, 32'h55AA_55AA);
        vecs[12] = make_vec(1'b0, 1'b1, 3'b001, 32'h0000_2000, 32'hABCD_1234, 1, 32'h0);
        vecs[13] = make_vec(1'b1, 1'b0, 3'b010, 32'h0000_1003, 32'h0, 1, 32'h0);

        // Hand constants pin down the headline vectors independently of make_vec.
        check("tbl_sb_be", 70'(vecs[1].be), 70'(4'b1000));
        check("tbl_sb_wdata", 70'(vecs[1].wdata), 70'(32'hA500_0000));
        check("tbl_sh_be", 70'(vecs[2].be), 70'(4'b1100));
        check("tbl_sh_wdata", 70'(vecs[2].wdata), 70'(32'h5678_0000));

        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 70'({dcache_read, dcache_write}), 70'(0));
        check("rst_addr", 70'(dcache_address), 70'(0));
        check("rst_wdata", 70'(dcache_wdata), 70'(0));
        check("rst_be", 70'(dcache_byte_enable), 70'(0));
        check("rst_wb", 70'(wb_mem_rdata), 70'(0));
        check("rst_timeout", 70'(timeout_err), 70'(0));
        check("rst_state", 70'(state_dbg), 70'(S_IDLE));
        check("rst_stall", 70'(dmem_stall), 70'(0));
        @(posedge clk); #3;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_txn(vecs[i]);

        for (int i = 0; i < 8; i++) begin
            sel = int'($urandom_range(0, 2));
            rd  = (sel != 1);
            wr  = (sel != 0);
            f3  = 3'($urandom_range(0, 2));
            if (!wr && f3 != 3'b010 && $urandom_range(0, 1) == 1) f3[2] = 1'b1;
            run_txn(make_vec(rd, wr, f3, $urandom, $urandom,
                             int'($urandom_range(1, 3)), $urandom));
        end

        // Store completes, pipeline held with req still high: exactly one write.
        req_before = req_seen;
        stall_n = 0;
        done_n  = 0;
        @(posedge clk); #1;
        drive_op(1'b0, 1'b1, 3'b010, 32'h0000_8000, 32'h1111_2222);
        exp_q.push_back({1'b0, 1'b1, 32'h0000_8000, 32'h1111_2222, 4'b1111});
        @(posedge clk); #1;
        dcache_resp = 1'b1;
        @(posedge clk); #1;
        dcache_resp = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            stall_n += int'(dmem_stall);
            done_n  += int'(state_dbg == S_DONE);
        end
        check("hold_write_pulses", 70'(req_seen - req_before), 70'(1));
        check("hold_stall", 70'(stall_n), 70'(0));
        check("hold_done_cycles", 70'(done_n), 70'(5));
        @(posedge clk); #1;
        pipe_adv  = 1'b1;
        mem_valid = 1'b0;
        @(posedge clk); #1;
        pipe_adv = 1'b0;
        @(negedge clk);
        check("hold_release_idle", 70'(state_dbg), 70'(S_IDLE));

        // Reset asserted mid-cycle while a load is outstanding.
        @(posedge clk); #1;
        drive_op(1'b1, 1'b0, 3'b010, 32'h0000_9000, 32'h0);
        exp_q.push_back({1'b1, 1'b0, 32'h0000_9000, 32'h0, 4'b1111});
        @(posedge clk); #1;
        @(negedge clk);
        check("busy_read", 70'({dcache_read, state_dbg}), 70'({1'b1, S_BUSY}));
        #2;
        rst_n     = 1'b0;
        mem_valid = 1'b0;
        #1;
        model_rdata = 32'h0;
        check("arst_read", 70'({dcache_read, dcache_write}), 70'(0));
        check("arst_state", 70'(state_dbg), 70'(S_IDLE));
        check("arst_addr_be", 70'({dcache_address, dcache_byte_enable}), 70'(0));
        check("arst_wb", 70'(wb_mem_rdata), 70'(0));
        check("arst_stall", 70'(dmem_stall), 70'(0));
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        dcache_resp  = 1'b1;
        dcache_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        dcache_resp = 1'b0;
        @(negedge clk);
        check("arst_spurious_wb", 70'(wb_mem_rdata), 70'(0));
        check("arst_spurious_state", 70'(state_dbg), 70'(S_IDLE));
        check("arst_spurious_req", 70'({dcache_read, dcache_write}), 70'(0));

        // Watchdog: no resp for 8 BUSY cycles, then a late resp.
        @(posedge clk); #1;
        drive_op(1'b1, 1'b0, 3'b010, 32'h0000_A000, 32'h0);
        exp_q.push_back({1'b1, 1'b0, 32'h0000_A000, 32'h0, 4'b1111});
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            mem_valid = 1'b0;
            @(negedge clk);
            check($sformatf("timeout_busy%0d", k), 70'(timeout_err), 70'(k >= 5));
        end
        @(posedge clk); #1;
        dcache_resp  = 1'b1;
        dcache_rdata = 32'h0F0F_1234;
        @(posedge clk); #1;
        dcache_resp = 1'b0;
        @(negedge clk);
        model_rdata = 32'h0F0F_1234;
        check("timeout_late_done", 70'(state_dbg), 70'(S_DONE));
        check("timeout_late_wb", 70'(wb_mem_rdata), 70'(model_rdata));
        check("timeout_sticky", 70'(timeout_err), 70'(1));
        @(posedge clk); #1;
        pipe_adv = 1'b1;
        @(posedge clk); #1;
        pipe_adv = 1'b0;
        @(negedge clk);
        check("timeout_idle_sticky", 70'({state_dbg, timeout_err}), 70'({S_IDLE, 1'b1}));
        #2;
        rst_n = 1'b0;
        #1;
        check("timeout_cleared_by_reset", 70'(timeout_err), 70'(0));
        @(posedge clk); #3;
        rst_n = 1'b1;

        repeat (2) @(posedge clk);
        check("exp_q_drained", 70'(exp_q.size()), 70'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
